// File: rtl/reflet_boot_sequencer.sv
// Boot loader for the Reflet controller: packs UART bytes into 16-bit RAM words, then releases the CPU.
// Latency: word written 1 cycle after its second byte; RUN follows timeout_cycles idle cycles after the last byte.
// Backpressure: none; rx bytes are accepted every strobe and words beyond mem_size_words are dropped (sticky overflow).
module reflet_boot_sequencer #(
    parameter int timeout_cycles = 1000,
    parameter int addr_width     = 8,
    parameter int mem_size_words = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  boot_enable,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic [addr_width:0]   loaded_words,
    output logic                  overflow,
    output logic                  done
);

    localparam int cnt_width = $clog2(timeout_cycles + 1);
    localparam int lw_width  = addr_width + 1;
    localparam logic [cnt_width-1:0] timeout_val = cnt_width'(timeout_cycles);
    localparam logic [cnt_width-1:0] cnt_one     = cnt_width'(1);
    localparam logic [lw_width-1:0]  full_count  = lw_width'(mem_size_words);
    localparam logic [lw_width-1:0]  lw_one      = lw_width'(1);

    typedef enum logic [1:0] {
        WAIT_FIRST,
        LOAD,
        FLUSH,
        RUN
    } state_t;

    state_t                state, state_next;
    logic                  byte_phase, phase_next;
    logic [7:0]            low_byte, low_next;
    logic [cnt_width-1:0]  idle_cnt, cnt_next;
    logic                  we_next;
    logic [addr_width-1:0] addr_next;
    logic [15:0]           wdata_next;
    logic                  hold_next;
    logic [lw_width-1:0]   loaded_next;
    logic                  ovf_next;
    logic                  done_next;
    logic                  word_vld;
    logic [15:0]           word_dat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_FIRST;
            byte_phase   <= 1'b0;
            low_byte     <= 8'h00;
            idle_cnt     <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 16'h0000;
            cpu_hold     <= 1'b1;
            loaded_words <= '0;
            overflow     <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_next;
            byte_phase   <= phase_next;
            low_byte     <= low_next;
            idle_cnt     <= cnt_next;
            mem_we       <= we_next;
            mem_addr     <= addr_next;
            mem_wdata    <= wdata_next;
            cpu_hold     <= hold_next;
            loaded_words <= loaded_next;
            overflow     <= ovf_next;
            done         <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        phase_next  = byte_phase;
        low_next    = low_byte;
        cnt_next    = idle_cnt;
        we_next     = 1'b0;
        addr_next   = mem_addr;
        wdata_next  = mem_wdata;
        hold_next   = cpu_hold;
        loaded_next = loaded_words;
        ovf_next    = overflow;
        done_next   = done;
        word_vld    = 1'b0;
        word_dat    = 16'h0000;

        case (state)
            WAIT_FIRST: begin
                // A byte outranks boot_enable=0 arriving in the same cycle.
                if (rx_valid) begin
                    state_next = LOAD;
                    low_next   = rx_data;
                    phase_next = 1'b1;
                    cnt_next   = '0;
                end else if (!boot_enable) begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (rx_valid) begin
                    cnt_next = '0;
                    if (byte_phase) begin
                        word_vld   = 1'b1;
                        word_dat   = {rx_data, low_byte};
                        phase_next = 1'b0;
                    end else begin
                        low_next   = rx_data;
                        phase_next = 1'b1;
                    end
                end else begin
                    if (idle_cnt != timeout_val) begin
                        cnt_next = idle_cnt + cnt_one;
                    end
                    // The write for a dangling low byte is issued here so mem_we is high during FLUSH.
                    if (cnt_next == timeout_val) begin
                        if (byte_phase) begin
                            state_next = FLUSH;
                            word_vld   = 1'b1;
                            word_dat   = {8'h00, low_byte};
                            phase_next = 1'b0;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
            end
            FLUSH: begin
                state_next = RUN;
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = WAIT_FIRST;
            end
        endcase

        if (word_vld) begin
            if (loaded_words == full_count) begin
                ovf_next = 1'b1;
            end else begin
                we_next     = 1'b1;
                addr_next   = loaded_words[addr_width-1:0];
                wdata_next  = word_dat;
                loaded_next = loaded_words + lw_one;
            end
        end

        if (state_next == RUN) begin
            hold_next = 1'b0;
            done_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_reflet_boot_sequencer.sv
// Directed bench for reflet_boot_sequencer: one 256-word instance and one 2-word instance share stimulus.
module tb_reflet_boot_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       boot_enable;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic       mem_we_a, cpu_hold_a, overflow_a, done_a;
    logic [7:0] mem_addr_a;
    logic [15:0] mem_wdata_a;
    logic [8:0] loaded_words_a;

    logic       mem_we_b, cpu_hold_b, overflow_b, done_b;
    logic [7:0] mem_addr_b;
    logic [15:0] mem_wdata_b;
    logic [8:0] loaded_words_b;

    int errors = 0;
    int checks = 0;
    int wr_a = 0;
    int wr_b = 0;
    int w0;
    int n;

    always #5 clk = ~clk;

    reflet_boot_sequencer #(.timeout_cycles(20), .addr_width(8), .mem_size_words(256)) dut_a (
        .clk(clk), .reset(reset), .boot_enable(boot_enable), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold_a),
        .loaded_words(loaded_words_a), .overflow(overflow_a), .done(done_a)
    );

    reflet_boot_sequencer #(.timeout_cycles(20), .addr_width(8), .mem_size_words(2)) dut_b (
        .clk(clk), .reset(reset), .boot_enable(boot_enable), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b),
        .loaded_words(loaded_words_b), .overflow(overflow_b), .done(done_b)
    );

    always @(negedge clk) begin
        if (mem_we_a === 1'b1) wr_a++;
        if (mem_we_b === 1'b1) wr_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        boot_enable = 1'b1;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tick();
        tick();
        check("rst_cpu_hold", 32'(cpu_hold_a), 32'h1);
        check("rst_mem_we", 32'(mem_we_a), 32'h0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata_a), 32'h0);
        check("rst_loaded", 32'(loaded_words_a), 32'h0);
        check("rst_overflow", 32'(overflow_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        reset = 1'b0;
        idle(3);

        // Basic load: six bytes spaced 10 cycles
        w0 = wr_a;
        send(8'h04);
        check("basic_b0_no_we", 32'(mem_we_a), 32'h0);
        idle(9);
        send(8'h03);
        check("basic_w0_we", 32'(mem_we_a), 32'h1);
        check("basic_w0_addr", 32'(mem_addr_a), 32'h0);
        check("basic_w0_data", 32'(mem_wdata_a), 32'h0304);
        check("basic_w0_loaded", 32'(loaded_words_a), 32'h1);
        tick();
        check("basic_we_drop", 32'(mem_we_a), 32'h0);
        check("basic_addr_hold", 32'(mem_addr_a), 32'h0);
        check("basic_data_hold", 32'(mem_wdata_a), 32'h0304);
        idle(8);
        send(8'h02);
        idle(9);
        send(8'h01);
        check("basic_w1_addr", 32'(mem_addr_a), 32'h1);
        check("basic_w1_data", 32'(mem_wdata_a), 32'h0102);
        idle(9);
        send(8'hE9);
        idle(9);
        send(8'hE8);
        check("basic_w2_we", 32'(mem_we_a), 32'h1);
        check("basic_w2_addr", 32'(mem_addr_a), 32'h2);
        check("basic_w2_data", 32'(mem_wdata_a), 32'hE8E9);
        check("basic_w2_loaded", 32'(loaded_words_a), 32'h3);
        n = 0;
        while (done_a !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("basic_run_latency", 32'(n), 32'd20);
        check("basic_cpu_hold", 32'(cpu_hold_a), 32'h0);
        check("basic_loaded", 32'(loaded_words_a), 32'h3);
        check("basic_overflow", 32'(overflow_a), 32'h0);
        check("basic_write_count", 32'(wr_a - w0), 32'd3);

        // Odd byte count: trailing byte flushed with zero high half
        do_reset();
        send(8'hAA);
        idle(9);
        send(8'hBB);
        check("odd_w0_addr", 32'(mem_addr_a), 32'h0);
        check("odd_w0_data", 32'(mem_wdata_a), 32'hBBAA);
        idle(9);
        send(8'hCC);
        n = 0;
        while (mem_we_a !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("odd_flush_latency", 32'(n), 32'd20);
        check("odd_flush_addr", 32'(mem_addr_a), 32'h1);
        check("odd_flush_data", 32'(mem_wdata_a), 32'h00CC);
        check("odd_flush_loaded", 32'(loaded_words_a), 32'h2);
        check("odd_flush_hold", 32'(cpu_hold_a), 32'h1);
        check("odd_flush_done", 32'(done_a), 32'h0);
        tick();
        check("odd_run_done", 32'(done_a), 32'h1);
        check("odd_run_hold", 32'(cpu_hold_a), 32'h0);
        check("odd_run_we", 32'(mem_we_a), 32'h0);

        // Skip boot
        boot_enable = 1'b0;
        do_reset();
        w0 = wr_a;
        check("skip_c1_done", 32'(done_a), 32'h0);
        check("skip_c1_hold", 32'(cpu_hold_a), 32'h1);
        tick();
        check("skip_c2_done", 32'(done_a), 32'h1);
        check("skip_c2_hold", 32'(cpu_hold_a), 32'h0);
        idle(5);
        check("skip_no_writes", 32'(wr_a - w0), 32'd0);
        check("skip_loaded", 32'(loaded_words_a), 32'h0);
        boot_enable = 1'b1;

        // Overflow on the 2-word instance
        do_reset();
        w0 = wr_b;
        send(8'h11);
        idle(2);
        send(8'h22);
        check("ovf_w0_we", 32'(mem_we_b), 32'h1);
        check("ovf_w0_addr", 32'(mem_addr_b), 32'h0);
        check("ovf_w0_data", 32'(mem_wdata_b), 32'h2211);
        idle(2);
        send(8'h33);
        idle(2);
        send(8'h44);
        check("ovf_w1_addr", 32'(mem_addr_b), 32'h1);
        check("ovf_w1_data", 32'(mem_wdata_b), 32'h4433);
        check("ovf_w1_loaded", 32'(loaded_words_b), 32'h2);
        idle(2);
        send(8'h55);
        idle(2);
        check("ovf_not_yet", 32'(overflow_b), 32'h0);
        send(8'h66);
        check("ovf_drop_we", 32'(mem_we_b), 32'h0);
        check("ovf_set", 32'(overflow_b), 32'h1);
        check("ovf_loaded_held", 32'(loaded_words_b), 32'h2);
        n = 0;
        while (done_b !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check("ovf_run_latency", 32'(n), 32'd20);
        check("ovf_run_loaded", 32'(loaded_words_b), 32'h2);
        check("ovf_run_sticky", 32'(overflow_b), 32'h1);
        check("ovf_write_count", 32'(wr_b - w0), 32'd2);
        check("ovf_big_loaded", 32'(loaded_words_a), 32'h3);
        check("ovf_big_overflow", 32'(overflow_a), 32'h0);

        // Byte lands on the cycle the idle counter would reach timeout
        do_reset();
        send(8'h01);
        idle(19);
        check("race_pre_done", 32'(done_a), 32'h0);
        send(8'h02);
        check("race_we", 32'(mem_we_a), 32'h1);
        check("race_data", 32'(mem_wdata_a), 32'h0201);
        check("race_no_run", 32'(done_a), 32'h0);
        idle(19);
        check("race_restart_done", 32'(done_a), 32'h0);
        check("race_restart_hold", 32'(cpu_hold_a), 32'h1);
        tick();
        check("race_run", 32'(done_a), 32'h1);
        w0 = wr_a;
        send(8'h77);
        check("run_ignore_we0", 32'(mem_we_a), 32'h0);
        send(8'h88);
        check("run_ignore_we1", 32'(mem_we_a), 32'h0);
        idle(2);
        check("run_ignore_loaded", 32'(loaded_words_a), 32'h1);
        check("run_ignore_count", 32'(wr_a - w0), 32'd0);

        // Reset in the middle of a load
        do_reset();
        send(8'hA1);
        idle(2);
        send(8'hA2);
        check("midrst_w0_data", 32'(mem_wdata_a), 32'hA2A1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_hold", 32'(cpu_hold_a), 32'h1);
        check("midrst_loaded", 32'(loaded_words_a), 32'h0);
        check("midrst_we", 32'(mem_we_a), 32'h0);
        check("midrst_addr", 32'(mem_addr_a), 32'h0);
        check("midrst_data", 32'(mem_wdata_a), 32'h0);
        check("midrst_done", 32'(done_a), 32'h0);
        idle(30);
        check("midrst_wait_first", 32'(done_a), 32'h0);
        send(8'hB1);
        idle(2);
        send(8'hB2);
        check("midrst_new_we", 32'(mem_we_a), 32'h1);
        check("midrst_new_addr", 32'(mem_addr_a), 32'h0);
        check("midrst_new_data", 32'(mem_wdata_a), 32'hB2B1);
        check("midrst_new_loaded", 32'(loaded_words_a), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
